alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand/result width in bits (legal range 4..64).
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  command/operands valid.
REQ-005 in_ready  output  1  block can accept a command this cycle.
REQ-006 cmd  input  4  opcode: 0 add, 1 sub, 2 mul, 3 div, 4 inv (negate), 5 rshift, 6 lshift, 7 and, 8 or, 9 nand, A nor, B xor, C not; D-F illegal.
REQ-007 op1  input  WIDTH  first operand.
REQ-008 op2  input  WIDTH  second operand; ignored for inv and not.
REQ-009 out_valid  output  1  result/flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  WIDTH  registered result.
REQ-012 flags  output  4  registered {err, ovf, carry, zero}, bit 3 to bit 0.

Function
REQ-013 A command SHALL be accepted on a rising edge where in_valid and in_ready are both 1; cmd/op1/op2 SHALL be captured on that edge.
REQ-014 FSM states SHALL be IDLE, CALC, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 IDLE: accepted mul or div (op2 nonzero) -> CALC; any other accepted cmd -> DONE with result computed on the accept edge (latency 1).
REQ-016 CALC: mul SHALL use iterative shift-add, div iterative restoring, one bit per cycle, WIDTH cycles, then -> DONE; command accepted at edge N gives out_valid high after edge N+WIDTH+1.
REQ-017 DONE: result and flags SHALL hold stable while out_ready is 0; out_valid & out_ready on an edge -> IDLE; a new command SHALL NOT be accepted on that same edge.
REQ-018 in_valid, cmd, op1, op2 changes during CALC or DONE SHALL have no effect.
REQ-019 add/sub: WIDTH-bit wrap result; carry = carry-out (add) or borrow (sub); ovf = signed two's-complement overflow.
REQ-020 mul: result = low WIDTH bits of unsigned product; carry = 1 if high WIDTH bits nonzero; ovf = 0.
REQ-021 div: unsigned quotient (op1/op2); op2 = 0 -> latency 1, result all ones, err = 1, no CALC.
REQ-022 inv: result = 0 - op1 (wrap); ovf = 1 iff op1 is most-negative value.
REQ-023 shifts: logical, amount = op2 unsigned; amount >= WIDTH -> result 0; carry = last bit shifted out (0 if amount 0).
REQ-024 and/or/nand/nor/xor/not: bitwise; carry = ovf = 0.
REQ-025 zero SHALL be 1 iff result is all zeros, for every cmd.
REQ-026 illegal cmd (D-F): result 0, err = 1, zero = 1, latency 1.
REQ-027 err SHALL be 0 for all other cases; flags not defined above SHALL be 0.

Reset
REQ-028 reset_n low SHALL immediately force state IDLE, in_ready 1 (from next sample), out_valid 0, result 0, flags 0, internal shift/accumulator registers 0.
REQ-029 reset asserted mid-CALC or in DONE SHALL abort the operation; no result SHALL appear after reset release.
REQ-030 First command SHALL be accepted on the first rising edge with reset_n high and in_valid high.

Verification (WIDTH = 8)
REQ-031 add 0x7F + 0x01, out_ready 1 -> out_valid one edge after accept, result 0x80, flags {0,1,0,0}; then 0xFF + 0x01 -> 0x00, flags {0,0,1,1}.
REQ-032 mul 0x10 * 0x20 -> in_ready low 9 cycles, out_valid after edge N+9, result 0x00, flags {0,0,1,1}; mul 0x0C*0x0B -> 0x84, carry 0.
REQ-033 div 0xC8 / 0x07 -> result 0x1C after WIDTH+1 edges; div 0x55 / 0x00 -> result 0xFF, err 1, latency 1.
REQ-034 lshift 0x81 by 1 -> 0x02, carry 1; rshift 0x81 by 8 -> 0x00, zero 1; cmd 0xE -> result 0, err 1.
REQ-035 out_ready held 0 for 5 cycles after sub 0x05-0x07 -> result 0xFE, carry 1 stable, in_ready 0, new in_valid ignored; out_ready 1 -> IDLE next edge.
REQ-036 reset_n pulsed low 4 cycles into a mul -> out_valid 0, result 0 immediately; no out_valid until a new command completes.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU with a valid/ready handshake on both sides.
// Single-cycle ops finish on the accept edge; mul (shift-add) and div (restoring)
// iterate one bit per cycle for WIDTH cycles in a CALC state before presenting the result.
//
// Ports:
//   clock, reset_n       clock and asynchronous active-low reset
//   in_valid, in_ready   command handshake (in_ready only while idle)
//   cmd, op1, op2        opcode and operands, captured on the accept edge
//   out_valid, out_ready result handshake (out_valid only while a result is held)
//   result, flags        registered result and {err, ovf, carry, zero}
module alu_pipe #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       cmd,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam int unsigned Msb  = WIDTH - 1;
   localparam logic [WIDTH-1:0] WLen = WIDTH'(WIDTH);
   localparam logic [WIDTH-1:0] One  = WIDTH'(1);

   localparam logic [3:0] OpAdd = 4'h0, OpSub = 4'h1, OpMul = 4'h2, OpDiv = 4'h3;
   localparam logic [3:0] OpInv = 4'h4, OpRsh = 4'h5, OpLsh = 4'h6, OpAnd = 4'h7;
   localparam logic [3:0] OpOr  = 4'h8, OpNand = 4'h9, OpNor = 4'hA, OpXor = 4'hB;
   localparam logic [3:0] OpNot = 4'hC;

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  acc_q, acc_d;     // mul: product high half; div: partial remainder
   logic [WIDTH-1:0]  lo_q, lo_d;       // mul: multiplier/product low; div: dividend/quotient
   logic [WIDTH-1:0]  opb_q, opb_d;     // multiplicand or divisor
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              is_div_q, is_div_d;
   logic [WIDTH-1:0]  result_q, result_d;
   logic [3:0]        flags_q, flags_d;

   // Single-cycle datapath
   logic [WIDTH:0]    ext;
   logic [WIDTH-1:0]  alu_res;
   logic              alu_err, alu_ovf, alu_carry;

   // Iterative datapath
   logic [WIDTH:0]    mul_sum;
   logic [WIDTH:0]    div_trial;
   logic [WIDTH-1:0]  div_diff;
   logic              div_ge;

   always_comb begin
      ext       = '0;
      alu_res   = '0;
      alu_err   = 1'b0;
      alu_ovf   = 1'b0;
      alu_carry = 1'b0;
      case (cmd)
         OpAdd: begin
            ext       = {1'b0, op1} + {1'b0, op2};
            alu_res   = ext[WIDTH-1:0];
            alu_carry = ext[WIDTH];
            alu_ovf   = (op1[Msb] == op2[Msb]) && (alu_res[Msb] != op1[Msb]);
         end
         OpSub: begin
            ext       = {1'b0, op1} - {1'b0, op2};
            alu_res   = ext[WIDTH-1:0];
            alu_carry = ext[WIDTH];
            alu_ovf   = (op1[Msb] != op2[Msb]) && (alu_res[Msb] != op1[Msb]);
         end
         OpMul: alu_res = '0;          // always iterates
         OpDiv: begin
            // Only reached for a zero divisor; nonzero divisors iterate
            alu_res = '1;
            alu_err = 1'b1;
         end
         OpInv: begin
            alu_res = '0 - op1;
            alu_ovf = (op1 == {1'b1, {(WIDTH-1){1'b0}}});
         end
         OpRsh: begin
            alu_res = (op2 < WLen) ? (op1 >> op2) : '0;
            // Last bit out is op1[amount-1]; past WIDTH only zeros leave
            if (op2 != '0 && op2 <= WLen) alu_carry = |(op1 & (One << (op2 - One)));
         end
         OpLsh: begin
            alu_res = (op2 < WLen) ? (op1 << op2) : '0;
            if (op2 != '0 && op2 <= WLen) alu_carry = |(op1 & (One << (WLen - op2)));
         end
         OpAnd:  alu_res = op1 & op2;
         OpOr:   alu_res = op1 | op2;
         OpNand: alu_res = ~(op1 & op2);
         OpNor:  alu_res = ~(op1 | op2);
         OpXor:  alu_res = op1 ^ op2;
         OpNot:  alu_res = ~op1;
         default: begin
            alu_res = '0;
            alu_err = 1'b1;
         end
      endcase
   end

   always_comb begin
      mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
      div_trial = {acc_q, lo_q[Msb]};
      div_ge    = (div_trial >= {1'b0, opb_q});
      // When div_ge holds the remainder is below the divisor, so WIDTH bits suffice
      div_diff  = div_trial[WIDTH-1:0] - opb_q;
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      lo_d     = lo_q;
      opb_d    = opb_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      result_d = result_q;
      flags_d  = flags_q;
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               if (cmd == OpMul || (cmd == OpDiv && op2 != '0)) begin
                  state_d  = StCalc;
                  acc_d    = '0;
                  lo_d     = op1;
                  opb_d    = op2;
                  cnt_d    = '0;
                  is_div_d = (cmd == OpDiv);
               end else begin
                  state_d  = StDone;
                  result_d = alu_res;
                  flags_d  = {alu_err, alu_ovf, alu_carry, alu_res == '0};
               end
            end
         end
         StCalc: begin
            if (cnt_q == CntW'(WIDTH)) begin
               // Extra cycle after the last step: publish the result
               state_d  = StDone;
               result_d = lo_q;
               flags_d  = {1'b0, 1'b0, is_div_q ? 1'b0 : (|acc_q), lo_q == '0};
            end else begin
               cnt_d = cnt_q + CntW'(1);
               if (is_div_q) begin
                  acc_d = div_ge ? div_diff : div_trial[WIDTH-1:0];
                  lo_d  = {lo_q[WIDTH-2:0], div_ge};
               end else begin
                  acc_d = mul_sum[WIDTH:1];
                  lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
               end
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         acc_q    <= '0;
         lo_q     <= '0;
         opb_q    <= '0;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         lo_q     <= lo_d;
         opb_q    <= opb_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign result    = result_q;
   assign flags     = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

   localparam int W = 8;

   logic         clock, reset_n, in_valid, in_ready, out_valid, out_ready;
   logic [3:0]   cmd, flags;
   logic [W-1:0] op1, op2, result;

   int checks = 0;
   int fails  = 0;

   // edges: rising edges from the accept edge (inclusive) until out_valid is seen
   typedef struct {
      logic [7:0] res;
      logic [3:0] flg;
      int         edges;
   } exp_t;

   exp_t exp_q[$];

   alu_pipe #(.WIDTH(W)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .cmd       (cmd),
      .op1       (op1),
      .op2       (op2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic exp_t model(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
      exp_t        e;
      int          s, sa, sbv;
      logic [15:0] e16;
      logic        err, ovf, cy;
      e.res = 8'h00; e.edges = 1; err = 0; ovf = 0; cy = 0;
      sa  = int'($signed(a));
      sbv = int'($signed(b));
      case (c)
         4'h0: begin s = int'(a) + int'(b); e.res = 8'(s); cy = (s > 255);
                     ovf = (sa + sbv > 127) || (sa + sbv < -128); end
         4'h1: begin s = int'(a) - int'(b); e.res = 8'(s); cy = (a < b);
                     ovf = (sa - sbv > 127) || (sa - sbv < -128); end
         4'h2: begin s = int'(a) * int'(b); e.res = 8'(s); cy = (s > 255); e.edges = 10; end
         4'h3: begin
            if (b == 0) begin e.res = 8'hFF; err = 1; end
            else begin e.res = 8'(int'(a) / int'(b)); e.edges = 10; end
         end
         4'h4: begin e.res = 8'(0 - int'(a)); ovf = (a == 8'h80); end
         4'h5: if (b <= 8) begin e16 = {a, 8'h00} >> b; e.res = e16[15:8]; cy = e16[7]; end
         4'h6: if (b <= 8) begin e16 = {8'h00, a} << b; e.res = e16[7:0]; cy = e16[8]; end
         4'h7: e.res = a & b;
         4'h8: e.res = a | b;
         4'h9: e.res = ~(a & b);
         4'hA: e.res = ~(a | b);
         4'hB: e.res = a ^ b;
         4'hC: e.res = ~a;
         default: err = 1;
      endcase
      e.flg = {err, ovf, cy, e.res == 8'h00};
      return e;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Issue one command and wait (bounded) for out_valid; inputs are scrambled
   // while the command is in flight. Leaves the result unconsumed.
   task automatic run_cmd(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                          output int edges, output int busy,
                          output logic [7:0] r, output logic [3:0] f);
      int guard = 0;
      while (!in_ready && guard < 40) begin step(); guard++; end
      in_valid = 1; cmd = c; op1 = a; op2 = b;
      step();
      edges = 1; busy = 0;
      while (!out_valid && edges < 40) begin
         in_valid = 1'($urandom); cmd = 4'($urandom); op1 = 8'($urandom); op2 = 8'($urandom);
         if (!in_ready) busy++;
         step();
         edges++;
      end
      in_valid = 0;
      r = result; f = flags;
   endtask

   task automatic test_reset();
      reset_n = 1; in_valid = 0; out_ready = 1; cmd = 0; op1 = 0; op2 = 0;
      #2 reset_n = 0;
      #1;
      checks++; if (out_valid !== 1'b0) begin fails++;
         $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (result !== 8'h00) begin fails++;
         $display("FAIL reset_result: got %h expected 00", result); end
      checks++; if (flags !== 4'h0) begin fails++;
         $display("FAIL reset_flags: got %b expected 0000", flags); end
      repeat (2) step();
      reset_n = 1;
      step();
      checks++; if (in_ready !== 1'b1) begin fails++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_directed();
      logic [3:0]  tc[12] = '{4'h0, 4'h0, 4'h2, 4'h2, 4'h3, 4'h3, 4'h6, 4'h5, 4'hE, 4'h4, 4'hC, 4'hA};
      logic [7:0]  ta[12] = '{8'h7F, 8'hFF, 8'h10, 8'h0C, 8'hC8, 8'h55, 8'h81, 8'h81, 8'h12, 8'h80, 8'h0F, 8'h00};
      logic [7:0]  tb[12] = '{8'h01, 8'h01, 8'h20, 8'h0B, 8'h07, 8'h00, 8'h01, 8'h08, 8'h34, 8'h00, 8'h99, 8'h00};
      logic [7:0]  tr[12] = '{8'h80, 8'h00, 8'h00, 8'h84, 8'h1C, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h80, 8'hF0, 8'hFF};
      logic [3:0]  tf[12] = '{4'b0100, 4'b0011, 4'b0011, 4'b0000, 4'b0000, 4'b1000,
                              4'b0010, 4'b0011, 4'b1001, 4'b0100, 4'b0000, 4'b0000};
      int          te[12] = '{1, 1, 10, 10, 10, 1, 1, 1, 1, 1, 1, 1};
      exp_t        e;
      int          edges, busy;
      logic [7:0]  r;
      logic [3:0]  f;
      out_ready = 1;
      for (int i = 0; i < 12; i++) begin
         e.res = tr[i]; e.flg = tf[i]; e.edges = te[i];
         exp_q.push_back(e);
         run_cmd(tc[i], ta[i], tb[i], edges, busy, r, f);
         e = exp_q.pop_front();
         checks++; if (r !== e.res) begin fails++;
            $display("FAIL directed%0d_result: got %h expected %h", i, r, e.res); end
         checks++; if (f !== e.flg) begin fails++;
            $display("FAIL directed%0d_flags: got %b expected %b", i, f, e.flg); end
         checks++; if (edges !== e.edges) begin fails++;
            $display("FAIL directed%0d_latency: got %0d expected %0d", i, edges, e.edges); end
         checks++; if (busy !== ((e.edges > 1) ? e.edges - 1 : 0)) begin fails++;
            $display("FAIL directed%0d_busy: got %0d expected %0d", i, busy,
                     (e.edges > 1) ? e.edges - 1 : 0); end
         step();
      end
   endtask

   task automatic test_random();
      exp_t       e;
      int         edges, busy;
      logic [3:0] c;
      logic [7:0] a, b, r;
      logic [3:0] f;
      out_ready = 1;
      for (int i = 0; i < 40; i++) begin
         c = 4'($urandom_range(0, 15));
         a = 8'($urandom);
         b = (c == 4'h5 || c == 4'h6) ? 8'($urandom_range(0, 10)) : 8'($urandom);
         exp_q.push_back(model(c, a, b));
         run_cmd(c, a, b, edges, busy, r, f);
         e = exp_q.pop_front();
         checks++; if (r !== e.res || f !== e.flg || edges !== e.edges) begin fails++;
            $display("FAIL random%0d cmd=%h a=%h b=%h: got %h/%b/%0d expected %h/%b/%0d",
                     i, c, a, b, r, f, edges, e.res, e.flg, e.edges); end
         step();
      end
   endtask

   task automatic test_stall();
      exp_t       e;
      int         edges, busy;
      logic [7:0] r;
      logic [3:0] f;
      out_ready = 0;
      exp_q.push_back(model(4'h1, 8'h05, 8'h07));
      run_cmd(4'h1, 8'h05, 8'h07, edges, busy, r, f);
      e = exp_q.pop_front();
      checks++; if (r !== e.res || f !== e.flg) begin fails++;
         $display("FAIL stall_first: got %h/%b expected %h/%b", r, f, e.res, e.flg); end
      for (int i = 0; i < 5; i++) begin
         in_valid = 1; cmd = 4'h0; op1 = 8'(i + 1); op2 = 8'h11;
         step();
         checks++; if (result !== 8'hFE || flags !== 4'b0010) begin fails++;
            $display("FAIL stall_hold%0d: got %h/%b expected fe/0010", i, result, flags); end
         checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin fails++;
            $display("FAIL stall_hs%0d: got rdy=%b vld=%b expected 0/1", i, in_ready, out_valid); end
      end
      in_valid = 0;
      out_ready = 1;
      step();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++;
         $display("FAIL stall_release: got rdy=%b vld=%b expected 1/0", in_ready, out_valid); end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      out_ready = 1;
      exp_q.push_back(model(4'h0, 8'h01, 8'h02));
      in_valid = 1; cmd = 4'h0; op1 = 8'h01; op2 = 8'h02;
      step();
      e = exp_q.pop_front();
      checks++; if (out_valid !== 1'b1 || result !== e.res) begin fails++;
         $display("FAIL b2b_first: got vld=%b %h expected 1 %h", out_valid, result, e.res); end
      // Keep in_valid high: the handshake edge must not also accept this command
      exp_q.push_back(model(4'hB, 8'hF0, 8'hFF));
      cmd = 4'hB; op1 = 8'hF0; op2 = 8'hFF;
      step();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++;
         $display("FAIL b2b_gap: got vld=%b rdy=%b expected 0/1", out_valid, in_ready); end
      step();
      in_valid = 0;
      e = exp_q.pop_front();
      checks++; if (out_valid !== 1'b1 || result !== e.res || flags !== e.flg) begin fails++;
         $display("FAIL b2b_second: got vld=%b %h/%b expected 1 %h/%b",
                  out_valid, result, flags, e.res, e.flg); end
      step();
   endtask

   task automatic test_reset_abort();
      int         seen = 0;
      exp_t       e;
      int         edges, busy;
      logic [7:0] r;
      logic [3:0] f;
      out_ready = 1;
      exp_q.push_back(model(4'h0, 8'h03, 8'h04));
      run_cmd(4'h0, 8'h03, 8'h04, edges, busy, r, f);
      e = exp_q.pop_front();
      checks++; if (r !== e.res) begin fails++;
         $display("FAIL abort_pre: got %h expected %h", r, e.res); end
      step();
      in_valid = 1; cmd = 4'h2; op1 = 8'h0C; op2 = 8'h0B;
      step();
      in_valid = 0;
      repeat (4) step();
      reset_n = 0;
      #1;
      checks++; if (out_valid !== 1'b0 || result !== 8'h00 || flags !== 4'h0) begin fails++;
         $display("FAIL abort_reset: got vld=%b %h/%b expected 0 00/0000",
                  out_valid, result, flags); end
      step();
      reset_n = 1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (out_valid === 1'b1) seen++;
      end
      checks++; if (seen !== 0) begin fails++;
         $display("FAIL abort_no_result: got %0d valid cycles expected 0", seen); end
      checks++; if (in_ready !== 1'b1) begin fails++;
         $display("FAIL abort_idle: got rdy=%b expected 1", in_ready); end
      exp_q.push_back(model(4'h2, 8'h0C, 8'h0B));
      run_cmd(4'h2, 8'h0C, 8'h0B, edges, busy, r, f);
      e = exp_q.pop_front();
      checks++; if (r !== e.res || f !== e.flg || edges !== e.edges) begin fails++;
         $display("FAIL abort_after: got %h/%b/%0d expected %h/%b/%0d",
                  r, f, edges, e.res, e.flg, e.edges); end
      step();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_stall();
      test_back_to_back();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
      $finish;
   end

endmodule
